// File: rtl/ps2_host_tx_if.sv
// PS/2 host transmit request/status bundle.
// master: the client that issues command bytes and watches status.
// slave : the ps2_host_tx engine that accepts bytes and reports outcome.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Inhibits the bus, issues request-to-send, then shifts out 8 data bits
// (LSB first), odd parity and stop on device clock falling edges, samples
// the device ACK on the 11th edge and reports done/err.
// Optional macro PS2_TX_TIMEOUT_EN adds a per-frame response timeout of
// TIMEOUT_CYCLES counted from request-to-send entry.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic          clk_50,
  input  logic          rst,
  ps2_host_tx_if.slave  host,
  input  logic          ps2_clk_in,
  input  logic          ps2_dat_in,
  output logic          ps2_clk_oe,
  output logic          ps2_dat_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    XFER,
    WAIT_IDLE,
    FINISH
  } state_t;

  state_t             state;
  logic [1:0]         clk_sync;
  logic [1:0]         dat_sync;
  logic               clk_prev;
  logic               clk_s;
  logic               dat_s;
  logic               clk_fall;
  logic [7:0]         data_reg;
  logic               parity;
  logic               ack_ok;
  logic [3:0]         k;
  logic [3:0]         k_inc;
  logic [INH_W-1:0]   inh_cnt;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0]    to_cnt;
`endif

  assign clk_s    = clk_sync[1];
  assign dat_s    = dat_sync[1];
  assign clk_fall = clk_prev & ~clk_s;
  assign k_inc    = k + 4'd1;

  // Two-flop synchronizers on the raw lines plus a delayed copy of the clock for edge detection.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_prev <= clk_s;
    end
  end

  // Frame sequencer: all line drives and status outputs are registered here.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state         <= IDLE;
      ps2_clk_oe    <= 1'b0;
      ps2_dat_oe    <= 1'b0;
      host.tx_ready <= 1'b1;
      host.busy     <= 1'b0;
      host.done     <= 1'b0;
      host.err      <= 1'b0;
      data_reg      <= 8'h00;
      parity        <= 1'b0;
      ack_ok        <= 1'b0;
      k             <= 4'd0;
      inh_cnt       <= '0;
`ifdef PS2_TX_TIMEOUT_EN
      to_cnt        <= '0;
`endif
    end else begin
      host.done <= 1'b0;
      host.err  <= 1'b0;

      case (state)
        IDLE: begin
          ps2_clk_oe    <= 1'b0;
          ps2_dat_oe    <= 1'b0;
          host.tx_ready <= 1'b1;
          host.busy     <= 1'b0;
          if (host.tx_valid && host.tx_ready) begin
            data_reg      <= host.tx_data;
            parity        <= ~^host.tx_data;
            inh_cnt       <= '0;
            ps2_clk_oe    <= 1'b1;
            host.tx_ready <= 1'b0;
            host.busy     <= 1'b1;
            state         <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b1;
            k          <= 4'd0;
`ifdef PS2_TX_TIMEOUT_EN
            to_cnt     <= '0;
`endif
            state      <= RTS;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end

        RTS: begin
          k     <= 4'd0;
          state <= XFER;
        end

        XFER: begin
          if (clk_fall) begin
            k <= k_inc;
            if (k_inc <= 4'd8) begin
              ps2_dat_oe <= ~data_reg[k[2:0]];
            end else if (k_inc == 4'd9) begin
              ps2_dat_oe <= ~parity;
            end else if (k_inc == 4'd10) begin
              ps2_dat_oe <= 1'b0;
            end else begin
              ack_ok <= ~dat_s;
              state  <= WAIT_IDLE;
            end
          end
        end

        WAIT_IDLE: begin
          if (clk_s && dat_s) begin
            host.done <= ack_ok;
            host.err  <= ~ack_ok;
            state     <= FINISH;
          end
        end

        FINISH: begin
          host.tx_ready <= 1'b1;
          host.busy     <= 1'b0;
          state         <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      if (state == RTS || state == XFER || state == WAIT_IDLE) begin
        if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          host.done  <= 1'b0;
          host.err   <= 1'b1;
          state      <= FINISH;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule
